// File: rtl/aes128_key_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_package
//  Description : Shared types, constants and round-constant lookup for the
//                iterative AES-128 key schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes128_package;

    typedef logic [7:0]   bv8_t;
    typedef logic [31:0]  bv32_t;
    typedef logic [127:0] bv128_t;
    typedef logic [3:0]   round_t;

    // Last round index of AES-128 (Nr)
    localparam round_t NUM_ROUNDS = 4'd10;

    // Schedule controller states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Round constant for rounds 1..10; any other index yields zero
    function automatic bv8_t rcon(input round_t r);
        bv8_t v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes128_key_sched_subword.sv
`default_nettype none
// ============================================================================
//  Module      : bv8_sbox / bv32_subword
//  Description : Byte S-box (forward or inverse) computed from GF(2^8)
//                inversion and the AES affine map, and a 32-bit SubWord
//                built from four forward S-boxes.
//  Revision    : 1.0 - initial release
// ============================================================================
module bv8_sbox
    import aes128_package::*;
(
    input  logic in_enc,
    input  bv8_t in_byte,
    output bv8_t out_byte
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic bv8_t gf_mul(input bv8_t a, input bv8_t b);
        bv8_t p;
        bv8_t x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires)
    function automatic bv8_t gf_inv(input bv8_t a);
        bv8_t sq;
        bv8_t acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic bv8_t rotl8(input bv8_t b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic bv8_t affine_fwd(input bv8_t b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic bv8_t affine_inv(input bv8_t b);
        return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
    endfunction

    // Forward: affine(inverse(x)); inverse S-box undoes the two steps in reverse
    always_comb begin
        out_byte = 8'h00;
        if (in_enc) begin
            out_byte = affine_fwd(gf_inv(in_byte));
        end else begin
            out_byte = gf_inv(affine_inv(in_byte));
        end
    end

endmodule

module bv32_subword
    import aes128_package::*;
(
    input  bv32_t in_word,
    output bv32_t out_word
);

    // Key expansion only ever needs the forward S-box
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        bv8_sbox u_sbox (
            .in_enc   (1'b1),
            .in_byte  (in_word[8*g +: 8]),
            .out_byte (out_word[8*g +: 8])
        );
    end

endmodule
`default_nettype wire

// File: rtl/aes128_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_key_sched
//  Description : Iterative bidirectional AES-128 key schedule. Forward mode
//                walks round keys 0..10 from the cipher key; backward mode
//                walks 10..0 from the last round key. One key per handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes128_key_sched
    import aes128_package::*;
(
    input  logic         in_clock,
    input  logic         in_reset,
    input  logic         in_start,
    input  logic         in_enc,
    input  logic [127:0] in_key,
    output logic         out_idle,
    output logic         out_valid,
    input  logic         in_ready,
    output logic [3:0]   out_round,
    output logic [127:0] out_key
);

    state_t state_q, state_d;
    bv128_t key_q,   key_d;
    round_t round_q, round_d;
    logic   dir_q,   dir_d;

    bv32_t  w0, w1, w2, w3;
    bv32_t  w_sub_src;
    bv32_t  w_sub_out;
    round_t w_rc_idx;
    bv32_t  w_rcw;
    bv32_t  w_tmp;
    bv128_t w_next_key;
    logic   w_last;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // Backward step needs SubWord of the already-recovered w3 (= w3 ^ w2),
    // so a single SubWord serves both directions through this mux.
    assign w_sub_src = dir_q ? w3 : (w3 ^ w2);

    bv32_subword u_subword (
        .in_word  ({w_sub_src[23:0], w_sub_src[31:24]}),
        .out_word (w_sub_out)
    );

    // Forward r->r+1 uses rcon[r+1]; backward r->r-1 uses rcon[r]
    assign w_rc_idx = dir_q ? round_t'(round_q + 4'd1) : round_q;
    assign w_rcw    = {rcon(w_rc_idx), 24'h000000};
    assign w_tmp    = w_sub_out ^ w_rcw;

    assign w_last   = dir_q ? (round_q == NUM_ROUNDS) : (round_q == 4'd0);

    // Next round key in the current direction
    always_comb begin
        bv32_t n0, n1, n2, n3;
        if (dir_q) begin
            n0 = w0 ^ w_tmp;
            n1 = w1 ^ n0;
            n2 = w2 ^ n1;
            n3 = w3 ^ n2;
        end else begin
            n3 = w3 ^ w2;
            n2 = w2 ^ w1;
            n1 = w1 ^ w0;
            n0 = w0 ^ w_tmp;
        end
        w_next_key = {n0, n1, n2, n3};
    end

    // Controller: load on start, advance on handshake, stop after final round
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (in_start) begin
                    state_d = ST_RUN;
                    key_d   = in_key;
                    dir_d   = in_enc;
                    round_d = in_enc ? 4'd0 : NUM_ROUNDS;
                end
            end
            ST_RUN: begin
                if (in_ready) begin
                    if (w_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        key_d   = w_next_key;
                        round_d = dir_q ? round_t'(round_q + 4'd1)
                                        : round_t'(round_q - 4'd1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            round_q <= 4'd0;
            dir_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            dir_q   <= dir_d;
        end
    end

    assign out_idle  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_RUN);
    assign out_round = round_q;
    assign out_key   = key_q;

endmodule
`default_nettype wire
